// File: rtl/realtank_soc_bus_pkg.sv
// Shared AHB encodings for the realtank bus matrix output stages, plus the
// fixed-burst length lookup used by the output arbiters.
package realtank_soc_bus_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  localparam int REMAIN_W = 4;

  // Beats still owed after the NONSEQ of a fixed-length burst; undefined
  // INCR and SINGLE return 0 because they are held by HTRANS alone.
  function automatic logic [REMAIN_W-1:0] burst_remain_f(input logic [2:0] hburst);
    logic [REMAIN_W-1:0] remain;
    remain = '0;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  remain = REMAIN_W'(3);
      HBURST_WRAP8,  HBURST_INCR8:  remain = REMAIN_W'(7);
      HBURST_WRAP16, HBURST_INCR16: remain = REMAIN_W'(15);
      default:                      remain = '0;
    endcase
    return remain;
  endfunction

endpackage

// File: rtl/realtank_soc_bus_rr_pick.sv
// Combinational round-robin picker: the first requester found scanning
// upward from rr_last+1 (wrapping) wins; rr_last itself is checked last.
module realtank_soc_bus_rr_pick #(
  parameter int NUM_PORTS = 3,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    rr_last,
  output logic [PORT_W-1:0]    winner,
  output logic                 any
);

  int                idx_i;
  logic [PORT_W-1:0] idx;

  // Scan from lowest to highest priority so the highest-priority hit is the
  // last assignment to stick.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx_i  = 0;
    idx    = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx_i = (int'(rr_last) + k) % NUM_PORTS;
      idx   = idx_i[PORT_W-1:0];
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/realtank_soc_bus_out_arb.sv
// MI0 output-stage arbiter: registered round-robin grant among the input
// stages, held across fixed bursts, undefined INCR bursts and locked sequences.
module realtank_soc_bus_out_arb
  import realtank_soc_bus_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int PORT_W    = 2
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HREADYM,
  input  logic [NUM_PORTS-1:0]     sel_op,
  input  logic [2*NUM_PORTS-1:0]   trans_op,
  input  logic [3*NUM_PORTS-1:0]   burst_op,
  input  logic [NUM_PORTS-1:0]     mastlock_op,
  input  logic [NUM_PORTS-1:0]     held_tran_op,
  output logic [PORT_W-1:0]        addr_in_port,
  output logic                     no_port,
  output logic [PORT_W-1:0]        data_in_port,
  output logic                     data_in_valid,
  output logic [NUM_PORTS-1:0]     active_op
);

  logic [PORT_W-1:0]   addr_in_port_q,  addr_in_port_d;
  logic                no_port_q,       no_port_d;
  logic [PORT_W-1:0]   data_in_port_q,  data_in_port_d;
  logic                data_in_valid_q, data_in_valid_d;
  logic [REMAIN_W-1:0] burst_remain_q,  burst_remain_d;
  logic                lock_hold_q,     lock_hold_d;
  logic [PORT_W-1:0]   rr_last_q,       rr_last_d;

  logic [NUM_PORTS-1:0] req;
  logic [1:0]           owner_trans;
  logic [2:0]           owner_burst;
  logic                 owner_lock;
  logic                 arb_ok;
  logic [PORT_W-1:0]    pick_winner;
  logic                 pick_any;

  // Owner fields read as IDLE/unlocked when nobody holds MI0, so an empty
  // port never blocks arbitration or sets the lock.
  always_comb begin
    req         = '0;
    owner_trans = HTRANS_IDLE;
    owner_burst = HBURST_SINGLE;
    owner_lock  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i] = sel_op[i] & (trans_op[2*i+1] | held_tran_op[i]);
      if (!no_port_q && (addr_in_port_q == PORT_W'(i))) begin
        owner_trans = trans_op[2*i +: 2];
        owner_burst = burst_op[3*i +: 3];
        owner_lock  = mastlock_op[i];
      end
    end
  end

  assign arb_ok = HREADYM & ~lock_hold_q & (burst_remain_q == '0) &
                  (owner_trans != HTRANS_SEQ) & (owner_trans != HTRANS_BUSY);

  realtank_soc_bus_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_rr_pick (
    .req     (req),
    .rr_last (rr_last_q),
    .winner  (pick_winner),
    .any     (pick_any)
  );

  // Every state update is gated by HREADYM, so a stalled MI0 freezes the
  // arbiter completely.
  always_comb begin
    addr_in_port_d  = addr_in_port_q;
    no_port_d       = no_port_q;
    data_in_port_d  = data_in_port_q;
    data_in_valid_d = data_in_valid_q;
    burst_remain_d  = burst_remain_q;
    lock_hold_d     = lock_hold_q;
    rr_last_d       = rr_last_q;

    if (HREADYM) begin
      if (arb_ok) begin
        if (pick_any) begin
          addr_in_port_d = pick_winner;
          no_port_d      = 1'b0;
          rr_last_d      = pick_winner;
        end else begin
          no_port_d      = 1'b1;
        end
      end

      // A NONSEQ always restarts the count, which also covers early burst
      // termination by a new burst; IDLE abandons whatever was left.
      case (owner_trans)
        HTRANS_NONSEQ: burst_remain_d = burst_remain_f(owner_burst);
        HTRANS_SEQ: begin
          if (burst_remain_q != '0) begin
            burst_remain_d = burst_remain_q - REMAIN_W'(1);
          end
        end
        HTRANS_IDLE:   burst_remain_d = '0;
        default:       burst_remain_d = burst_remain_q;
      endcase

      lock_hold_d     = owner_lock & (lock_hold_q | owner_trans[1]);
      data_in_port_d  = addr_in_port_q;
      data_in_valid_d = ~no_port_q & owner_trans[1];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port_q  <= '0;
      no_port_q       <= 1'b1;
      data_in_port_q  <= '0;
      data_in_valid_q <= 1'b0;
      burst_remain_q  <= '0;
      lock_hold_q     <= 1'b0;
      rr_last_q       <= PORT_W'(NUM_PORTS - 1);
    end else begin
      addr_in_port_q  <= addr_in_port_d;
      no_port_q       <= no_port_d;
      data_in_port_q  <= data_in_port_d;
      data_in_valid_q <= data_in_valid_d;
      burst_remain_q  <= burst_remain_d;
      lock_hold_q     <= lock_hold_d;
      rr_last_q       <= rr_last_d;
    end
  end

  always_comb begin
    active_op = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      active_op[i] = ~no_port_q & (addr_in_port_q == PORT_W'(i));
    end
  end

  assign addr_in_port  = addr_in_port_q;
  assign no_port       = no_port_q;
  assign data_in_port  = data_in_port_q;
  assign data_in_valid = data_in_valid_q;

endmodule

// File: tb/tb_realtank_soc_bus_out_arb.sv
// Bench for the MI0 output arbiter: directed scenarios and random traffic,
// each cycle compared against a behavioural model of the arbitration rules.
module tb_realtank_soc_bus_out_arb;

  localparam int N  = 3;
  localparam int PW = 2;
  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_NSEQ = 2'd2;
  localparam logic [1:0] T_SEQ  = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_INCR8  = 3'd5;
  localparam logic [2:0] B_INCR16 = 3'd7;
  // {no_port, addr_in_port, data_in_port, data_in_valid, active_op}
  localparam logic [8:0] RESET_VEC = 9'b1_00_00_0_000;

  logic           HCLK, HRESETn, HREADYM;
  logic [N-1:0]   sel_op, mastlock_op, held_tran_op;
  logic [2*N-1:0] trans_op;
  logic [3*N-1:0] burst_op;
  logic [PW-1:0]  addr_in_port, data_in_port;
  logic           no_port, data_in_valid;
  logic [N-1:0]   active_op;

  logic [N-1:0] sl, ml, hd;
  logic [1:0]   tr [N];
  logic [2:0]   hb [N];

  always_comb begin
    sel_op       = sl;
    mastlock_op  = ml;
    held_tran_op = hd;
    trans_op     = '0;
    burst_op     = '0;
    for (int i = 0; i < N; i++) begin
      trans_op[2*i +: 2] = tr[i];
      burst_op[3*i +: 3] = hb[i];
    end
  end

  // Reference model state: owner port (or none), beats owed, lock, last winner.
  int m_addr, m_rem, m_rr, m_dport;
  bit m_nop, m_lock, m_dval;
  int vec, err;

  wire [8:0] obs = {no_port, addr_in_port, data_in_port, data_in_valid, active_op};

  realtank_soc_bus_out_arb #(.NUM_PORTS(N), .PORT_W(PW)) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .HREADYM       (HREADYM),
    .sel_op        (sel_op),
    .trans_op      (trans_op),
    .burst_op      (burst_op),
    .mastlock_op   (mastlock_op),
    .held_tran_op  (held_tran_op),
    .addr_in_port  (addr_in_port),
    .no_port       (no_port),
    .data_in_port  (data_in_port),
    .data_in_valid (data_in_valid),
    .active_op     (active_op)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [8:0] exp_vec();
    logic [N-1:0] act;
    act = '0;
    for (int i = 0; i < N; i++) if (!m_nop && m_addr == i) act[i] = 1'b1;
    return {m_nop, PW'(m_addr), PW'(m_dport), m_dval, act};
  endfunction

  function automatic int burst_len(input int code);
    return (code < 2) ? 0 : (4 << ((code - 2) / 2)) - 1;
  endfunction

  task automatic model_reset();
    m_addr = 0; m_nop = 1'b1; m_rem = 0; m_lock = 1'b0;
    m_rr = N - 1; m_dport = 0; m_dval = 1'b0;
  endtask

  // Advance one clock: the model's next state comes from the inputs seen
  // before the edge; the check point is 1 ns after the edge.
  task automatic tick();
    bit upd, arb, lk, n_nop, n_lock, n_dval;
    int ot, hbv, w, n_addr, n_rem, n_rr, n_dport;
    upd = HRESETn && HREADYM;
    n_addr = m_addr; n_nop = m_nop; n_rem = m_rem; n_lock = m_lock;
    n_rr = m_rr; n_dport = m_dport; n_dval = m_dval;
    if (upd) begin
      ot  = m_nop ? 0 : int'(tr[m_addr]);
      hbv = int'(hb[m_addr]);
      lk  = !m_nop && ml[m_addr];
      arb = !m_lock && (m_rem == 0) && (ot != 1) && (ot != 3);
      if (arb) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          int p;
          p = (m_rr + k) % N;
          if (w < 0 && sl[p] && (tr[p][1] || hd[p])) w = p;
        end
        if (w >= 0) begin n_addr = w; n_nop = 1'b0; n_rr = w; end
        else n_nop = 1'b1;
      end
      if (ot == 2) n_rem = burst_len(hbv);
      else if (ot == 3) n_rem = (m_rem > 0) ? m_rem - 1 : 0;
      else if (ot == 0) n_rem = 0;
      n_lock  = lk && (m_lock || ot >= 2);
      n_dport = m_addr;
      n_dval  = !m_nop && ot >= 2;
    end
    @(posedge HCLK);
    #1;
    if (!HRESETn) model_reset();
    else if (upd) begin
      m_addr = n_addr; m_nop = n_nop; m_rem = n_rem; m_lock = n_lock;
      m_rr = n_rr; m_dport = n_dport; m_dval = n_dval;
    end
  endtask

  task automatic idle_all();
    sl = '0; ml = '0; hd = '0; HREADYM = 1'b1;
    for (int i = 0; i < N; i++) begin tr[i] = T_IDLE; hb[i] = B_SINGLE; end
  endtask

  task automatic test_reset();
    idle_all();
    HRESETn = 1'b1;
    #1 HRESETn = 1'b0;
    #1;
    if (obs !== RESET_VEC) begin err++; $display("FAIL reset_async got=%b want=%b", obs, RESET_VEC); end
    vec++;
    model_reset();
    repeat (2) begin
      @(posedge HCLK); #1;
      if (obs !== RESET_VEC) begin err++; $display("FAIL reset_held got=%b want=%b", obs, RESET_VEC); end
      vec++;
    end
    #2 HRESETn = 1'b1;
  endtask

  task automatic test_idle();
    idle_all();
    for (int c = 0; c < 8; c++) begin
      tick();
      if (obs !== exp_vec()) begin err++; $display("FAIL idle c=%0d got=%b want=%b", c, obs, exp_vec()); end
      vec++;
      if ({no_port, data_in_valid, active_op} !== 5'b1_0_000) begin
        err++; $display("FAIL idle_const c=%0d got=%b want=10000", c, {no_port, data_in_valid, active_op});
      end
      vec++;
    end
  endtask

  task automatic test_round_robin();
    idle_all();
    for (int i = 0; i < N; i++) begin sl[i] = 1'b1; tr[i] = T_NSEQ; end
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (obs !== exp_vec()) begin err++; $display("FAIL rr k=%0d got=%b want=%b", k, obs, exp_vec()); end
      vec++;
      if (no_port !== 1'b0 || addr_in_port !== PW'((k - 1) % N)) begin
        err++; $display("FAIL rr_order k=%0d got=%0d/%b want=%0d/0", k, addr_in_port, no_port, (k - 1) % N);
      end
      vec++;
    end
    idle_all();
    repeat (2) tick();
  endtask

  task automatic test_burst_hold();
    int b;
    bit own, acc;
    idle_all();
    sl[1] = 1'b1; tr[1] = T_NSEQ; hb[1] = B_INCR8;
    b = 0;
    for (int c = 0; c < 200 && b < 8; c++) begin
      own = !m_nop && m_addr == 1;
      if (own) tr[1] = (b == 0) ? T_NSEQ : T_SEQ;
      sl[0] = (b >= 1);
      tr[0] = (b >= 1) ? T_NSEQ : T_IDLE;
      HREADYM = (b >= 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      acc = own && HREADYM;
      tick();
      if (acc) b++;
      if (obs !== exp_vec()) begin err++; $display("FAIL burst c=%0d got=%b want=%b", c, obs, exp_vec()); end
      vec++;
      if (b >= 1 && (no_port !== 1'b0 || addr_in_port !== 2'd1)) begin
        err++; $display("FAIL burst_hold beat=%0d got=%0d/%b want=1/0", b, addr_in_port, no_port);
      end
      vec++;
    end
    if (b < 8) begin err++; $display("FAIL burst_timeout beats=%0d want=8", b); end
    vec++;
    tr[1] = T_IDLE; sl[1] = 1'b0; HREADYM = 1'b1;
    tick();
    if (obs !== exp_vec()) begin err++; $display("FAIL burst_rel got=%b want=%b", obs, exp_vec()); end
    vec++;
    if (no_port !== 1'b0 || addr_in_port !== 2'd0) begin
      err++; $display("FAIL burst_handover got=%0d/%b want=0/0", addr_in_port, no_port);
    end
    vec++;
  endtask

  task automatic test_ebt();
    int b;
    bit own;
    idle_all();
    sl[2] = 1'b1; tr[2] = T_NSEQ; hb[2] = B_INCR4;
    b = 0;
    for (int c = 0; c < 50 && b < 2; c++) begin
      own = !m_nop && m_addr == 2;
      if (own) tr[2] = (b == 0) ? T_NSEQ : T_SEQ;
      sl[0] = (b >= 1);
      tr[0] = (b >= 1) ? T_NSEQ : T_IDLE;
      tick();
      if (own) b++;
      if (obs !== exp_vec()) begin err++; $display("FAIL ebt c=%0d got=%b want=%b", c, obs, exp_vec()); end
      vec++;
    end
    tr[2] = T_IDLE; sl[2] = 1'b0;
    tick();
    if (no_port !== 1'b0 || addr_in_port !== 2'd2) begin
      err++; $display("FAIL ebt_idle_edge got=%0d/%b want=2/0", addr_in_port, no_port);
    end
    vec++;
    tick();
    if (obs !== exp_vec()) begin err++; $display("FAIL ebt_rel got=%b want=%b", obs, exp_vec()); end
    vec++;
    if (no_port !== 1'b0 || addr_in_port !== 2'd0) begin
      err++; $display("FAIL ebt_handover got=%0d/%b want=0/0", addr_in_port, no_port);
    end
    vec++;
  endtask

  task automatic test_lock();
    logic [1:0] st [6] = '{T_NSEQ, T_IDLE, T_NSEQ, T_IDLE, T_NSEQ, T_IDLE};
    logic       sk [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    idle_all();
    sl[0] = 1'b1; tr[0] = T_NSEQ; ml[0] = 1'b1;
    for (int c = 0; c < 20 && !(!m_nop && m_addr == 0); c++) tick();
    if (!(!m_nop && m_addr == 0) || obs !== exp_vec()) begin
      err++; $display("FAIL lock_grant got=%b want=%b", obs, exp_vec());
    end
    vec++;
    for (int j = 0; j < 6; j++) begin
      tr[0] = st[j]; ml[0] = sk[j];
      for (int p = 1; p < N; p++) begin sl[p] = (j >= 1); tr[p] = (j >= 1) ? T_NSEQ : T_IDLE; end
      tick();
      if (obs !== exp_vec()) begin err++; $display("FAIL lock j=%0d got=%b want=%b", j, obs, exp_vec()); end
      vec++;
      if (no_port !== 1'b0 || addr_in_port !== 2'd0) begin
        err++; $display("FAIL lock_hold j=%0d got=%0d/%b want=0/0", j, addr_in_port, no_port);
      end
      vec++;
    end
    tr[0] = T_IDLE; ml[0] = 1'b0;
    tick();
    if (no_port !== 1'b0 || addr_in_port !== 2'd1) begin
      err++; $display("FAIL lock_release got=%0d/%b want=1/0", addr_in_port, no_port);
    end
    vec++;
  endtask

  task automatic test_reset_mid_burst();
    int b;
    bit own;
    idle_all();
    sl[1] = 1'b1; tr[1] = T_NSEQ; hb[1] = B_INCR16;
    b = 0;
    for (int c = 0; c < 100 && b < 5; c++) begin
      own = !m_nop && m_addr == 1;
      if (own) tr[1] = (b == 0) ? T_NSEQ : T_SEQ;
      sl[0] = (b >= 1); tr[0] = (b >= 1) ? T_NSEQ : T_IDLE;
      sl[2] = (b >= 1); tr[2] = (b >= 1) ? T_NSEQ : T_IDLE;
      tick();
      if (own) b++;
      if (obs !== exp_vec()) begin err++; $display("FAIL rstb c=%0d got=%b want=%b", c, obs, exp_vec()); end
      vec++;
    end
    #2 HRESETn = 1'b0;
    #1;
    if (obs !== RESET_VEC) begin err++; $display("FAIL rst_mid got=%b want=%b", obs, RESET_VEC); end
    vec++;
    model_reset();
    tick();
    #2 HRESETn = 1'b1;
    idle_all();
    for (int i = 0; i < N; i++) begin sl[i] = 1'b1; tr[i] = T_NSEQ; end
    tick();
    if (obs !== exp_vec()) begin err++; $display("FAIL rst_after got=%b want=%b", obs, exp_vec()); end
    vec++;
    if (no_port !== 1'b0 || addr_in_port !== 2'd0) begin
      err++; $display("FAIL rst_first_grant got=%0d/%b want=0/0", addr_in_port, no_port);
    end
    vec++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      sl = N'($urandom);
      hd = N'($urandom & $urandom);
      ml = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      for (int i = 0; i < N; i++) begin tr[i] = 2'($urandom); hb[i] = 3'($urandom); end
      HREADYM = ($urandom_range(0, 3) != 0);
      tick();
      if (obs !== exp_vec()) begin err++; $display("FAIL random c=%0d got=%b want=%b", c, obs, exp_vec()); end
      vec++;
    end
  endtask

  initial begin
    vec = 0;
    err = 0;
    model_reset();
    test_reset();
    test_idle();
    test_round_robin();
    test_burst_hold();
    test_ebt();
    test_lock();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
